// File: rtl/motor_pkg.sv
// motor_pkg: shared widths, FSM states and saturation helpers for the PID scheduler
package motor_pkg;
  localparam int DATA_W = 24;
  localparam int LIM_W  = 10;
  localparam int ACC_W  = 64;
  typedef enum logic [3:0] {IDLE, FETCH, LATCH, ERR, MUL_P, MUL_I, MUL_D, OUT, NEXT} state_e;
  // Integral saturation; a negative limit collapses the window to zero
  function automatic logic signed [DATA_W-1:0] sat_int(input logic signed [32:0] v,
                                                       input logic signed [DATA_W-1:0] lim);
    logic signed [32:0] l;
    l = lim[DATA_W-1] ? '0 : 33'(lim);
    return DATA_W'(v > l ? l : v < -l ? -l : v);
  endfunction
  function automatic logic signed [DATA_W-1:0] clamp64(input logic signed [ACC_W-1:0] v,
                                                       input logic signed [ACC_W-1:0] lim);
    return DATA_W'(v > lim ? lim : v < -lim ? -lim : v);
  endfunction
endpackage

// File: rtl/pid_sat_clamp.sv
// pid_sat_clamp: deadband zeroing followed by symmetric PWM limit clamp
module pid_sat_clamp
  import motor_pkg::*;
(
  input  logic signed [ACC_W-1:0]  acc_i,
  input  logic signed [LIM_W-1:0]  deadband_i,
  input  logic signed [LIM_W-1:0]  limit_i,
  output logic signed [DATA_W-1:0] pwm_o
);
  logic signed [ACC_W-1:0] db;
  assign db = ACC_W'(deadband_i);
  assign pwm_o = (acc_i >= -db && acc_i <= db) ? '0 : clamp64(acc_i, ACC_W'(limit_i));
endmodule

// File: rtl/motor_pid_scheduler.sv
// motor_pid_scheduler: tick-driven PID sweep over all motors sharing one multiplier
module motor_pid_scheduler
  import motor_pkg::*;
#(
  parameter int NUM_MOTORS = 6,
  parameter int AW = 4
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [23:0]              loop_period,
  output logic                     cfg_rd,
  output logic [AW-1:0]            cfg_addr,
  input  logic signed [DATA_W-1:0] setpoint,
  input  logic signed [DATA_W-1:0] state,
  input  logic signed [DATA_W-1:0] Kp,
  input  logic signed [DATA_W-1:0] Ki,
  input  logic signed [DATA_W-1:0] Kd,
  input  logic signed [DATA_W-1:0] IntegralLimit,
  input  logic signed [LIM_W-1:0]  PWMLimit,
  input  logic signed [LIM_W-1:0]  deadband,
  output logic                     pwm_wr,
  output logic [AW-1:0]            pwm_addr,
  output logic signed [DATA_W-1:0] pwm_data,
  output logic                     busy,
  output logic                     overrun
);
  localparam int DEPTH = 1 << AW;
  state_e state_q;
  logic [AW-1:0] idx_q, pwm_addr_q;
  logic [23:0] cnt_q, cnt_d, lp_m1;
  logic tick, cfg_rd_q, pwm_wr_q, busy_q, overrun_q;
  logic signed [DATA_W-1:0] sp_q, st_q, kp_q, ki_q, kd_q, il_q, pwm_data_q, int_d, mul_a, pwm_c;
  logic signed [LIM_W-1:0] pl_q, db_q;
  logic signed [31:0] err_q, err_d;
  logic signed [32:0] mul_b;
  logic signed [56:0] prod;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [31:0] err_prev_q [DEPTH];
  logic signed [DATA_W-1:0] integ_q [DEPTH];
  assign lp_m1 = (loop_period == '0) ? '0 : loop_period - 24'd1;
  assign tick  = cnt_q >= lp_m1;
  assign cnt_d = tick ? '0 : cnt_q + 24'd1;
  assign err_d = 32'(st_q) - 32'(sp_q);
  assign int_d = sat_int(33'(integ_q[idx_q]) + 33'(err_d), il_q);
  // Single shared multiplier: gain and operand are steered by the MUL_* state
  assign mul_a = state_q == MUL_P ? kp_q : state_q == MUL_I ? ki_q : kd_q;
  assign mul_b = state_q == MUL_P ? 33'(err_q) : state_q == MUL_I ? 33'(integ_q[idx_q])
               : 33'(err_prev_q[idx_q]) - 33'(err_q);
  assign prod  = 57'(mul_a) * 57'(mul_b);
  pid_sat_clamp u_clamp (
    .acc_i      (acc_q),
    .deadband_i (db_q),
    .limit_i    (pl_q),
    .pwm_o      (pwm_c)
  );
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      cnt_q <= '0;
      cfg_rd_q <= 1'b0;
      pwm_wr_q <= 1'b0;
      pwm_addr_q <= '0;
      pwm_data_q <= '0;
      busy_q <= 1'b0;
      overrun_q <= 1'b0;
      {sp_q, st_q, kp_q, ki_q, kd_q, il_q, pl_q, db_q} <= '0;
      err_q <= '0;
      acc_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        err_prev_q[i] <= '0;
        integ_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      cfg_rd_q <= 1'b0;
      pwm_wr_q <= 1'b0;
      if (tick && busy_q) overrun_q <= 1'b1;
      case (state_q)
        IDLE: if (tick && enable) begin
          state_q <= FETCH;
          idx_q <= '0;
          cfg_rd_q <= 1'b1;
          busy_q <= 1'b1;
        end
        FETCH: state_q <= LATCH;
        LATCH: begin
          {sp_q, st_q, kp_q, ki_q, kd_q, il_q} <= {setpoint, state, Kp, Ki, Kd, IntegralLimit};
          {pl_q, db_q} <= {PWMLimit, deadband};
          state_q <= ERR;
        end
        ERR: begin
          err_q <= err_d;
          integ_q[idx_q] <= int_d;
          state_q <= MUL_P;
        end
        MUL_P: begin
          acc_q <= ACC_W'(prod);
          state_q <= MUL_I;
        end
        MUL_I: begin
          acc_q <= acc_q + ACC_W'(prod);
          state_q <= MUL_D;
        end
        MUL_D: begin
          acc_q <= acc_q + ACC_W'(prod);
          err_prev_q[idx_q] <= err_q;
          state_q <= OUT;
        end
        OUT: begin
          pwm_wr_q <= 1'b1;
          pwm_addr_q <= idx_q;
          pwm_data_q <= pwm_c;
          state_q <= NEXT;
        end
        NEXT: if (idx_q == AW'(NUM_MOTORS - 1)) begin
          state_q <= IDLE;
          busy_q <= 1'b0;
        end else begin
          idx_q <= idx_q + 1'b1;
          cfg_rd_q <= 1'b1;
          state_q <= FETCH;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign cfg_rd   = cfg_rd_q;
  assign cfg_addr = idx_q;
  assign pwm_wr   = pwm_wr_q;
  assign pwm_addr = pwm_addr_q;
  assign pwm_data = pwm_data_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;
endmodule

// File: tb/tb_motor_pid_scheduler.sv
// tb_motor_pid_scheduler: directed PID sweeps checked through an expected-write scoreboard
module tb_motor_pid_scheduler;
  logic CLK, reset, enable;
  logic [23:0] loop_period;
  logic cfg_rd, pwm_wr, busy, overrun;
  logic [0:0] cfg_addr, pwm_addr;
  logic [23:0] setpoint, state, Kp, Ki, Kd, IntegralLimit, pwm_data;
  logic [9:0] PWMLimit, deadband;
  logic [23:0] sp_m[2], st_m[2], kp_m[2], ki_m[2], kd_m[2], il_m[2];
  logic [9:0] pl_m[2], db_m[2];
  logic rd_addr;
  typedef struct {logic [0:0] addr; logic [23:0] data;} exp_t;
  exp_t q[$];
  int tests, fails, cyc, rd_cyc, wr_cyc, wr_cnt;
  logic last_pend;

  motor_pid_scheduler #(.NUM_MOTORS(2), .AW(1)) dut (
    .CLK(CLK), .reset(reset), .enable(enable), .loop_period(loop_period),
    .cfg_rd(cfg_rd), .cfg_addr(cfg_addr), .setpoint(setpoint), .state(state),
    .Kp(Kp), .Ki(Ki), .Kd(Kd), .IntegralLimit(IntegralLimit),
    .PWMLimit(PWMLimit), .deadband(deadband), .pwm_wr(pwm_wr), .pwm_addr(pwm_addr),
    .pwm_data(pwm_data), .busy(busy), .overrun(overrun)
  );

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) if (cfg_rd) rd_addr <= cfg_addr[0];
  assign setpoint = sp_m[rd_addr];
  assign state = st_m[rd_addr];
  assign Kp = kp_m[rd_addr];
  assign Ki = ki_m[rd_addr];
  assign Kd = kd_m[rd_addr];
  assign IntegralLimit = il_m[rd_addr];
  assign PWMLimit = pl_m[rd_addr];
  assign deadband = db_m[rd_addr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_m(input logic m, input int sp, st, kp, ki, kd, il, pl, db);
    sp_m[m] = 24'(sp); st_m[m] = 24'(st); kp_m[m] = 24'(kp); ki_m[m] = 24'(ki);
    kd_m[m] = 24'(kd); il_m[m] = 24'(il); pl_m[m] = 10'(pl); db_m[m] = 10'(db);
  endtask

  task automatic push(input logic a, input int d);
    q.push_back('{a, 24'(d)});
  endtask

  task automatic start(input logic [23:0] lp);
    reset = 1; enable = 0; loop_period = lp;
    q.delete();
    repeat (2) @(negedge CLK);
    reset = 0; enable = 1;
  endtask

  task automatic wait_writes(input int n, input string name);
    int target;
    target = wr_cnt + n;
    for (int i = 0; i < 3000 && wr_cnt < target; i++) @(posedge CLK);
    enable = 0;
    tests++;
    if (wr_cnt < target) begin
      fails++;
      $display("FAIL %s: timeout, writes seen %0d expected %0d", name, wr_cnt, target);
    end
  endtask

  task automatic wait_cfg0(input string name);
    logic found;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge CLK);
      found = cfg_rd && cfg_addr == 1'b0;
    end
    chk(name, found, 1);
  endtask

  // Monitor: pops the scoreboard on every pwm_wr and checks strobe timing
  always @(negedge CLK) begin
    cyc++;
    if (reset) last_pend = 0;
    else begin
      if (last_pend) chk("busy_drop", busy, 0);
      last_pend = 0;
      if (cfg_rd) begin
        rd_cyc = cyc;
        chk("strobe_excl", pwm_wr, 0);
      end
      if (pwm_wr) begin
        wr_cnt++;
        chk("wr_latency", cyc - rd_cyc, 7);
        chk("busy_at_wr", busy, 1);
        if (pwm_addr == 1'b1) begin
          chk("addr_gap", cyc - wr_cyc, 8);
          last_pend = 1;
        end
        wr_cyc = cyc;
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_wr: addr %0d data %0h with empty queue", pwm_addr, pwm_data);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("pwm_addr", pwm_addr, e.addr);
          chk("pwm_data", pwm_data, e.data);
        end
      end
    end
  end

  initial begin
    int base;
    tests = 0; fails = 0; cyc = 0; rd_cyc = 0; wr_cyc = 0; wr_cnt = 0; last_pend = 0;
    reset = 1; enable = 0; loop_period = 100; rd_addr = 0;
    // 1: proportional, timing and reset values
    set_m(0, 0, 10, 2, 0, 0, 0, 100, 0);
    set_m(1, 0, 0, 0, 0, 0, 0, 100, 0);
    #1;
    chk("rst_cfg_rd", cfg_rd, 0);
    chk("rst_pwm_wr", pwm_wr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_pwm_data", pwm_data, 0);
    chk("rst_addr", {cfg_addr, pwm_addr}, 0);
    start(100);
    push(0, 20); push(1, 0);
    wait_writes(2, "t1_prop");
    // 2: PWM saturation both directions
    set_m(0, 0, 1000, 1, 0, 0, 0, 100, 0);
    set_m(1, 1000, 0, 1, 0, 0, 0, 100, 0);
    start(100);
    push(0, 100); push(1, -100);
    wait_writes(2, "t2_sat");
    // 3: deadband inside / outside
    set_m(0, 0, 3, 1, 0, 0, 0, 100, 5);
    set_m(1, 0, 6, 1, 0, 0, 0, 100, 5);
    start(100);
    push(0, 0); push(1, 6);
    wait_writes(2, "t3_db");
    // 4: integral windup limit over four ticks
    set_m(0, 0, 10, 0, 1, 0, 25, 100, 0);
    set_m(1, 0, 0, 0, 1, 0, 25, 100, 0);
    start(100);
    push(0, 10); push(1, 0); push(0, 20); push(1, 0);
    push(0, 25); push(1, 0); push(0, 25); push(1, 0);
    enable = 1;
    base = wr_cnt;
    for (int i = 0; i < 3000 && wr_cnt < base + 8; i++) @(posedge CLK);
    wait_writes(0, "t4_int");
    chk("t4_count", wr_cnt - base, 8);
    // 5: derivative on error change between ticks
    set_m(0, 0, 5, 0, 0, 1, 0, 100, 0);
    set_m(1, 0, -4, 0, 0, 2, 0, 100, 0);
    start(100);
    push(0, -5); push(1, 8);
    wait_writes(2, "t5_d1");
    st_m[0] = 24'd8;
    enable = 1;
    push(0, -3); push(1, 0);
    wait_writes(2, "t5_d2");
    // 6: overrun, mid-sweep reset, enable drop mid-sweep, idle with enable low
    set_m(0, 0, 10, 0, 1, 0, 1000, 100, 0);
    set_m(1, 0, 0, 0, 0, 0, 0, 100, 0);
    start(10);
    push(0, 10); push(1, 0);
    base = wr_cnt;
    for (int i = 0; i < 200 && wr_cnt < base + 2; i++) @(posedge CLK);
    chk("t6_sweep1", wr_cnt - base, 2);
    chk("overrun_set", overrun, 1);
    wait_cfg0("t6_sweep2_start");
    chk("overrun_sticky", overrun, 1);
    repeat (3) @(negedge CLK);
    reset = 1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_pwm_wr", pwm_wr, 0);
    chk("abort_overrun", overrun, 0);
    q.delete();
    @(negedge CLK);
    reset = 0;
    push(0, 10); push(1, 0);
    wait_cfg0("t6_restart");
    enable = 0;
    wait_writes(2, "t6_restart_wr");
    base = wr_cnt;
    repeat (60) @(negedge CLK);
    chk("disabled_no_wr", wr_cnt - base, 0);
    chk("disabled_busy", busy, 0);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/motor_pid_scheduler.md
Name: motor_pid_scheduler

Overview:
Time-multiplexed PID sequencer serving NUM_MOTORS motor channels with a single shared signed multiplier. On every control tick it sweeps motors 0..NUM_MOTORS-1 in order. For each motor it fetches setpoint, state, gains and limits from the register file, computes the PID result with deadband and PWM clamping, and writes the signed pwm word to that motor's commutation block. It sits between the SPI-fed register file and the per-motor commutation/PWM stages.

Parameters:
NUM_MOTORS, 6, number of channels swept per tick (1..16)
AW, 4, width of the motor index (clog2 of NUM_MOTORS, minimum 1)

Ports:
CLK  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  1 = ticks start sweeps; 0 = ticks ignored
loop_period  in  24  CLK cycles per control tick (tick when counter reaches loop_period-1); 0 is treated as 1
cfg_rd  out  1  one-cycle read strobe to register file
cfg_addr  out  AW  motor index being fetched; valid with cfg_rd
setpoint, state, Kp, Ki, Kd  in  24 each, signed  register-file data, valid on the cycle after cfg_rd
IntegralLimit  in  24 signed  same timing as setpoint
PWMLimit, deadband  in  10 each, signed  same timing as setpoint
pwm_wr  out  1  one-cycle write strobe
pwm_addr  out  AW  motor index for pwm_data
pwm_data  out  24 signed  clamped PID output
busy  out  1  high from sweep start until the last pwm_wr inclusive
overrun  out  1  sticky; set when a tick arrives while busy; cleared only by reset

Behaviour:
- Reset: all outputs 0; FSM in IDLE; tick counter 0; per-motor err_prev[] and integral[] arrays 0.
- Tick counter: free-running; wraps to 0 on tick; runs whether or not enable is high.
- Tick handling when enable=1 and idle: start a sweep at index 0 on the next cycle.
- Tick handling when busy: set overrun and drop the tick. The sweep continues.
- enable deassertion mid-sweep: the current sweep completes.
- FSM per motor, exactly 8 cycles:
  - FETCH: cfg_rd=1, cfg_addr=idx.
  - LATCH: capture all cfg inputs.
  - ERR: err = sext32(state) - sext32(setpoint). Integral update: integral[idx] + err, saturated to [-IntegralLimit, +IntegralLimit]. A negative IntegralLimit is treated as 0.
  - MUL_P: acc = Kp*err.
  - MUL_I: acc += Ki*integral.
  - MUL_D: acc += Kd*(err_prev[idx] - err). Write err_prev[idx] = err.
  - OUT: compute pwm_data as below.
  - NEXT: idx+1. After NUM_MOTORS-1, return to IDLE and drop busy the following cycle.
- Arithmetic: acc is 64-bit signed; the multiplier is 24x33 signed. No intermediate truncation.
- OUT rules:
  - If -deadband <= acc <= deadband (deadband sign-extended), pwm_data = 0.
  - Else if acc > PWMLimit, pwm_data = PWMLimit.
  - Else if acc < -PWMLimit, pwm_data = -PWMLimit.
  - Else pwm_data = acc[23:0].
  - pwm_wr=1 and pwm_addr=idx in this cycle.
- Sweep latency: first pwm_wr 7 cycles after the first cfg_rd. Total sweep = 8*NUM_MOTORS cycles. loop_period < 8*NUM_MOTORS+1 guarantees overrun.
- Reset mid-sweep: aborts immediately. No further strobes. Arrays cleared.
- Only one of cfg_rd / pwm_wr is high in any cycle.

Decomposition:
- Shared package motor_pkg:
  - FSM state enum (IDLE, FETCH, LATCH, ERR, MUL_P, MUL_I, MUL_D, OUT, NEXT)
  - widths: DATA_W=24, LIM_W=10, ACC_W=64
  - saturate/clamp helper functions
- One sub-module pid_sat_clamp: combinational deadband plus ±PWMLimit clamp, 64-bit acc in, 24-bit out. Reused by the single-motor controller.

Test Plan:
1. NUM_MOTORS=2, loop_period=100, motor0 setpoint=0, state=10, Kp=2, Ki=Kd=0, PWMLimit=100, deadband=0 -> pwm_wr addr0 data=20, 7 cycles after the first cfg_rd; addr1 written 8 cycles later; busy low after cycle 16.
2. Saturation: state-setpoint=1000, Kp=1, PWMLimit=100 -> pwm_data=100. With -1000 -> pwm_data=-100 (0xFFFF9C).
3. Deadband: err=3, Kp=1, deadband=5 -> pwm_data=0. Then err=6 -> pwm_data=6.
4. Integral: Ki=1, Kp=Kd=0, err=10, IntegralLimit=25, three ticks -> pwm_data 10, 20, 25, then stays 25. Motor1 integral remains 0.
5. Derivative: Kd=1, Kp=Ki=0, err 5 then 8 on consecutive ticks -> pwm_data -5 then -3.
6. loop_period=10 with NUM_MOTORS=2 -> overrun=1 after the first sweep and stays set. Asserting reset mid-sweep drops busy and pwm_wr immediately, clears overrun, and the next sweep's integral restarts from 0.
